// File: rtl/traffic_demand_sensor_if.sv
// Sensor/light inputs and queue/request outputs of the demand sensor.
// master drives loops and lights; slave is the sensor itself.
interface traffic_demand_sensor_if #(
  parameter int QW = 5
);
  logic          car_ns;
  logic          car_ew;
  logic [2:0]    ns_light;
  logic [2:0]    ew_light;
  logic [QW-1:0] ns_queue;
  logic [QW-1:0] ew_queue;
  logic          high_ns;
  logic          high_ew;
  logic          light_fault;

  modport master (
    output car_ns, car_ew, ns_light, ew_light,
    input  ns_queue, ew_queue, high_ns, high_ew, light_fault
  );

  modport slave (
    input  car_ns, car_ew, ns_light, ew_light,
    output ns_queue, ew_queue, high_ns, high_ew, light_fault
  );
endinterface

// File: rtl/traffic_demand_sensor.sv
// Per-approach queue estimate from loop sensors and green time,
// with hysteretic high-traffic requests and a sticky light fault.
module traffic_demand_sensor #(
  parameter int QW            = 5,
  parameter int HIGH_ON       = 8,
  parameter int HIGH_OFF      = 3,
  parameter int DEPART_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  traffic_demand_sensor_if.slave bus
);

  localparam logic [QW-1:0] QMAX  = '1;
  localparam logic [QW-1:0] ON_T  = QW'(HIGH_ON);
  localparam logic [QW-1:0] OFF_T = QW'(HIGH_OFF);
  localparam logic [3:0]    DLAST = 4'(DEPART_CYCLES - 1);

  // index 0 is NS, index 1 is EW
  logic [1:0]    car;
  logic [2:0]    lt [2];
  logic [1:0]    s1, s2, s3;
  logic [3:0]    dcnt [2];
  logic [QW-1:0] q [2];
  logic [QW-1:0] q_nx [2];
  logic [1:0]    high, high_nx;
  logic [1:0]    arr, dep, grn;
  logic          fault, fault_now;

  assign car   = {bus.car_ew, bus.car_ns};
  assign lt[0] = bus.ns_light;
  assign lt[1] = bus.ew_light;

  function automatic logic legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  // Illegal encodings, or neither approach showing red
  always_comb begin
    fault_now = !legal(bus.ns_light) || !legal(bus.ew_light) ||
                ((bus.ns_light != 3'b100) && (bus.ew_light != 3'b100));
  end

  // Arrival/departure events and the resulting queue and request
  always_comb begin
    arr     = '0;
    dep     = '0;
    grn     = '0;
    high_nx = high;
    q_nx    = q;
    for (int d = 0; d < 2; d++) begin
      arr[d] = s2[d] & ~s3[d];
      grn[d] = (lt[d] == 3'b001) && !fault;
      dep[d] = grn[d] && (dcnt[d] == DLAST);
      if (arr[d] && !dep[d] && (q[d] != QMAX))
        q_nx[d] = q[d] + 1'b1;
      else if (dep[d] && !arr[d] && (q[d] != '0))
        q_nx[d] = q[d] - 1'b1;
      if (q_nx[d] >= ON_T)
        high_nx[d] = 1'b1;
      else if (q_nx[d] <= OFF_T)
        high_nx[d] = 1'b0;
    end
  end

  // Synchronizers, depart counters, queues, requests and fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      high  <= '0;
      fault <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        dcnt[d] <= '0;
        q[d]    <= '0;
      end
    end else begin
      s1    <= car;
      s2    <= s1;
      s3    <= s2;
      high  <= high_nx;
      fault <= fault | fault_now;
      for (int d = 0; d < 2; d++) begin
        q[d]    <= q_nx[d];
        dcnt[d] <= (grn[d] && !dep[d]) ? dcnt[d] + 4'd1 : 4'd0;
      end
    end
  end

  assign bus.ns_queue    = q[0];
  assign bus.ew_queue    = q[1];
  assign bus.high_ns     = high[0];
  assign bus.high_ew     = high[1];
  assign bus.light_fault = fault;

endmodule

// File: tb/tb_traffic_demand_sensor.sv
// Directed scenarios for traffic_demand_sensor; expectations are
// queued by cycle and checked by an independent monitor.
module tb_traffic_demand_sensor;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pcyc = 0;
  int   now = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    string      nm;
    logic [4:0] nq;
    logic [4:0] eq;
    logic       hn;
    logic       he;
    logic       lf;
  } exp_t;

  exp_t sb[$];

  traffic_demand_sensor_if #(.QW(5)) bus ();

  traffic_demand_sensor #(
    .QW(5), .HIGH_ON(8), .HIGH_OFF(3), .DEPART_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic drive(input logic cn, input logic ce,
                       input logic [2:0] nl, input logic [2:0] el);
    @(negedge clk);
    bus.car_ns   = cn;
    bus.car_ew   = ce;
    bus.ns_light = nl;
    bus.ew_light = el;
    now = pcyc;
  endtask

  task automatic expect_at(input int c, input string nm,
                           input logic [4:0] nq, input logic [4:0] eq,
                           input logic hn, input logic he, input logic lf);
    exp_t e;
    e.cyc = c; e.nm = nm;
    e.nq = nq; e.eq = eq;
    e.hn = hn; e.he = he; e.lf = lf;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at this falling edge
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= pcyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc < pcyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d not checked, now %0d",
                   e.nm, e.cyc, pcyc);
        end else if ({bus.ns_queue, bus.ew_queue, bus.high_ns,
                      bus.high_ew, bus.light_fault} !==
                     {e.nq, e.eq, e.hn, e.he, e.lf}) begin
          n_fail++;
          $display("FAIL %s @%0d: got nq=%0d eq=%0d hn=%b he=%b lf=%b want nq=%0d eq=%0d hn=%b he=%b lf=%b",
                   e.nm, pcyc, bus.ns_queue, bus.ew_queue, bus.high_ns,
                   bus.high_ew, bus.light_fault,
                   e.nq, e.eq, e.hn, e.he, e.lf);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int ew_exp;
    bus.car_ns   = 1'b0;
    bus.car_ew   = 1'b0;
    bus.ns_light = RED;
    bus.ew_light = RED;

    // reset held: all outputs zero
    expect_at(1, "reset_a", 0, 0, 0, 0, 0);
    expect_at(2, "reset_b", 0, 0, 0, 0, 0);
    drive(0, 0, RED, RED);
    drive(0, 0, RED, RED);
    reset = 1'b0;
    expect_at(now + 1, "post_reset", 0, 0, 0, 0, 0);

    // 9 NS pulses with NS red; high_ns rises as queue reaches 8
    for (int i = 0; i < 9; i++) begin
      for (int s = 0; s < 6; s++) begin
        drive(s < 3, 0, RED, RED);
        if (s == 0)
          expect_at(now + 3, "ns_arrive", 5'(i + 1), 0, i >= 7, 0, 0);
      end
    end

    // NS green 18 cycles: departure every 3rd edge, 9 -> 3
    for (int k = 0; k < 18; k++) begin
      drive(0, 0, GRN, RED);
      if (k == 0) begin
        base = now;
        expect_at(base + 3,  "ns_dep8", 8, 0, 1, 0, 0);
        expect_at(base + 6,  "ns_dep7", 7, 0, 1, 0, 0);
        expect_at(base + 9,  "ns_dep6", 6, 0, 1, 0, 0);
        expect_at(base + 12, "ns_dep5", 5, 0, 1, 0, 0);
        expect_at(base + 15, "ns_dep4", 4, 0, 1, 0, 0);
        expect_at(base + 18, "ns_dep3", 3, 0, 0, 0, 0);
      end
    end

    // 40 EW pulses with EW red: saturate at 31
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 4; s++) begin
        drive(0, s < 2, RED, RED);
        if (s == 0) begin
          ew_exp = (i + 1 > 31) ? 31 : i + 1;
          expect_at(now + 3, "ew_arrive", 3, 5'(ew_exp), 0, i >= 7, 0);
        end
      end
    end

    // EW green: arrival and departure on the same edge at 31
    drive(0, 1, RED, GRN);
    base = now;
    expect_at(base + 3, "ew_arr_dep_max", 3, 31, 0, 1, 0);
    expect_at(base + 4, "ew_hold_max", 3, 31, 0, 1, 0);
    drive(0, 1, RED, GRN);
    drive(0, 0, RED, GRN);
    drive(0, 0, RED, RED);

    // NS green: drain 3 -> 0, no underflow, arrival+departure at 0
    for (int k = 0; k < 21; k++) begin
      drive(k == 18 || k == 19, 0, GRN, RED);
      if (k == 0) begin
        base = now;
        expect_at(base + 3,  "ns_drain2", 2, 31, 0, 1, 0);
        expect_at(base + 6,  "ns_drain1", 1, 31, 0, 1, 0);
        expect_at(base + 9,  "ns_drain0", 0, 31, 0, 1, 0);
        expect_at(base + 12, "ns_floor_a", 0, 31, 0, 1, 0);
        expect_at(base + 19, "ns_floor_b", 0, 31, 0, 1, 0);
        expect_at(base + 21, "ns_arr_dep_zero", 0, 31, 0, 1, 0);
        expect_at(base + 22, "ns_zero_after", 0, 31, 0, 1, 0);
      end
    end
    drive(0, 0, RED, RED);

    // both green for one cycle: sticky fault, no departures after
    drive(0, 0, GRN, GRN);
    base = now;
    expect_at(base + 1, "fault_set", 0, 31, 0, 1, 1);
    for (int k = 1; k < 27; k++) begin
      drive(k >= 2 && k <= 23 && ((k - 2) % 4) < 2, 0, GRN, RED);
      if (k >= 2 && k <= 23 && ((k - 2) % 4) == 0)
        expect_at(now + 3, "fault_arrive",
                  5'((k - 2) / 4 + 1), 31, 0, 1, 1);
    end

    // async reset mid-count: outputs clear before any clock edge
    @(posedge clk);
    #2 reset = 1'b1;
    expect_at(pcyc, "reset_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    expect_at(pcyc, "reset_release", 0, 0, 0, 0, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++)
      @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
